// File: rtl/mips_exec_mem_pkg.sv
// rtl/mips_exec_mem_pkg.sv - shared opcode/func constants, ALU op encoding and memory depth default
package mips_exec_mem_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    localparam int MEM_DEPTH_DEFAULT = 256;

endpackage

// File: rtl/mips_exec_mem_if.sv
// rtl/mips_exec_mem_if.sv - instruction/operand inputs and decoded/result outputs of the exec-mem stage
interface mips_exec_mem_if;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm32;
    logic        RegDst;
    logic        RegWrite;
    logic        MemToReg;
    logic        ALUSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        branch;
    logic [1:0]  ALUOperation;
    logic [31:0] alu_result;
    logic        zero;
    logic        branch_taken;
    logic [31:0] write_data_reg;

    // Instruction source (pipeline front end or bench)
    modport master (
        output opcode, func, read_data1, read_data2, imm32,
        input  RegDst, RegWrite, MemToReg, ALUSrc, MemRead, MemWrite, branch,
        input  ALUOperation, alu_result, zero, branch_taken, write_data_reg
    );

    // The exec-mem stage itself
    modport slave (
        input  opcode, func, read_data1, read_data2, imm32,
        output RegDst, RegWrite, MemToReg, ALUSrc, MemRead, MemWrite, branch,
        output ALUOperation, alu_result, zero, branch_taken, write_data_reg
    );
endinterface

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational 32-bit add/sub/and/or ALU with zero flag
import mips_exec_mem_pkg::*;

module exec_alu (
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero
);

    // Operation select; arithmetic wraps modulo 2^32, no overflow reporting
    always_comb begin
        result = '0;
        unique case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
        endcase
    end

    assign zero = (result == 32'h0);

endmodule

// File: rtl/mips_exec_mem.sv
// rtl/mips_exec_mem.sv - MIPS decode, ALU and data memory stage; MIPS_EXEC_ADDI_EN enables addi decode
import mips_exec_mem_pkg::*;

module mips_exec_mem #(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    mips_exec_mem_if.slave  bus
);

    localparam int AW = $clog2(MEM_DEPTH);

    alu_op_e     alu_op;
    logic [31:0] alu_b;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem [MEM_DEPTH];

    // Control decode; anything unrecognised falls through to an all-zero NOP
    always_comb begin
        bus.RegDst   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemToReg = 1'b0;
        bus.ALUSrc   = 1'b0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.branch   = 1'b0;
        alu_op       = ALU_ADD;
        case (bus.opcode)
            OP_RTYPE: begin
                case (bus.func)
                    FUNC_ADD: begin bus.RegDst = 1'b1; bus.RegWrite = 1'b1; alu_op = ALU_ADD; end
                    FUNC_SUB: begin bus.RegDst = 1'b1; bus.RegWrite = 1'b1; alu_op = ALU_SUB; end
                    FUNC_AND: begin bus.RegDst = 1'b1; bus.RegWrite = 1'b1; alu_op = ALU_AND; end
                    FUNC_OR:  begin bus.RegDst = 1'b1; bus.RegWrite = 1'b1; alu_op = ALU_OR;  end
                    default: ;
                endcase
            end
            OP_LW: begin
                bus.ALUSrc   = 1'b1;
                bus.MemRead  = 1'b1;
                bus.MemToReg = 1'b1;
                bus.RegWrite = 1'b1;
                alu_op       = ALU_ADD;
            end
            OP_SW: begin
                bus.ALUSrc   = 1'b1;
                bus.MemWrite = 1'b1;
                alu_op       = ALU_ADD;
            end
            OP_BEQ: begin
                bus.branch = 1'b1;
                alu_op     = ALU_SUB;
            end
`ifdef MIPS_EXEC_ADDI_EN
            OP_ADDI: begin
                bus.ALUSrc   = 1'b1;
                bus.RegWrite = 1'b1;
                alu_op       = ALU_ADD;
            end
`else
            // addi left undecoded: behaves as a NOP
            OP_ADDI: ;
`endif
            default: ;
        endcase
    end

    assign bus.ALUOperation = alu_op;
    assign alu_b            = bus.ALUSrc ? bus.imm32 : bus.read_data2;

    exec_alu u_alu (
        .op     (alu_op),
        .a      (bus.read_data1),
        .b      (alu_b),
        .result (alu_result),
        .zero   (zero)
    );

    assign bus.alu_result   = alu_result;
    assign bus.zero         = zero;
    assign bus.branch_taken = bus.branch & zero;

    // Word address: byte offset and bits above the array size are dropped so addresses alias
    assign mem_addr = alu_result[AW+1:2];

    // Data memory: whole array cleared while in reset, stores only once out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.MemWrite) begin
            mem[mem_addr] <= bus.read_data2;
        end
    end

    // Asynchronous read port, forced to zero when not reading or while in reset
    assign mem_rdata = (bus.MemRead && rst) ? mem[mem_addr] : 32'h0;

    assign bus.write_data_reg = bus.MemToReg ? mem_rdata : alu_result;

endmodule

// File: tb/tb_mips_exec_mem.sv
// tb/tb_mips_exec_mem.sv - scoreboard bench for mips_exec_mem with directed vectors
module tb_mips_exec_mem;

    localparam int MEM_DEPTH = 256;

    typedef struct {
        string       name;
        logic [8:0]  ctrl;   // {RegDst,RegWrite,MemToReg,ALUSrc,MemRead,MemWrite,branch,ALUOperation}
        logic [31:0] alu;
        logic        zero;
        logic        bt;
        logic [31:0] wdr;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    mips_exec_mem_if bif ();

    mips_exec_mem #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one instruction just after a rising edge and queue what it must produce
    task automatic apply(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [8:0] ctrl, input logic [31:0] alu, input logic zero,
                         input logic bt, input logic [31:0] wdr);
        exp_t e;
        @(posedge clk);
        #1;
        bif.opcode     = op;
        bif.func       = fn;
        bif.read_data1 = a;
        bif.read_data2 = b;
        bif.imm32      = imm;
        e.name = name; e.ctrl = ctrl; e.alu = alu; e.zero = zero; e.bt = bt; e.wdr = wdr;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are stable mid-cycle; pop and compare there
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [8:0] act_ctrl;
            logic       bad;
            e = exp_q.pop_front();
            act_ctrl = {bif.RegDst, bif.RegWrite, bif.MemToReg, bif.ALUSrc, bif.MemRead,
                        bif.MemWrite, bif.branch, bif.ALUOperation};
            bad = 1'b0;
            vectors++;
            if (act_ctrl !== e.ctrl) begin
                $display("FAIL %s ctrl: got %b expected %b", e.name, act_ctrl, e.ctrl); bad = 1'b1;
            end
            if (bif.alu_result !== e.alu) begin
                $display("FAIL %s alu_result: got %h expected %h", e.name, bif.alu_result, e.alu); bad = 1'b1;
            end
            if (bif.zero !== e.zero) begin
                $display("FAIL %s zero: got %b expected %b", e.name, bif.zero, e.zero); bad = 1'b1;
            end
            if (bif.branch_taken !== e.bt) begin
                $display("FAIL %s branch_taken: got %b expected %b", e.name, bif.branch_taken, e.bt); bad = 1'b1;
            end
            if (bif.write_data_reg !== e.wdr) begin
                $display("FAIL %s write_data_reg: got %h expected %h", e.name, bif.write_data_reg, e.wdr); bad = 1'b1;
            end
            if (bad) miscompares++;
        end
    end

    localparam logic [8:0] C_ADD  = 9'b110000000;
    localparam logic [8:0] C_SUB  = 9'b110000001;
    localparam logic [8:0] C_AND  = 9'b110000010;
    localparam logic [8:0] C_OR   = 9'b110000011;
    localparam logic [8:0] C_NOP  = 9'b000000000;
    localparam logic [8:0] C_BEQ  = 9'b000000101;
    localparam logic [8:0] C_SW   = 9'b000101000;
    localparam logic [8:0] C_LW   = 9'b011110000;
    localparam logic [8:0] C_ADDI = 9'b010100000;

    initial begin
        int budget;
        vectors     = 0;
        miscompares = 0;
        bif.opcode = '0; bif.func = '0; bif.read_data1 = '0; bif.read_data2 = '0; bif.imm32 = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Reset-state memory: freshly cleared word reads back 0
        apply("lw_after_reset", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'd0);

        apply("r_add", 6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0, C_ADD, 32'd12, 1'b0, 1'b0, 32'd12);
        apply("r_sub_zero", 6'b000000, 6'b100010, 32'd5, 32'd5, 32'd0, C_SUB, 32'd0, 1'b1, 1'b0, 32'd0);
        apply("r_and", 6'b000000, 6'b100100, 32'h0000F0F0, 32'h00000FF0, 32'd0, C_AND, 32'h000000F0, 1'b0, 1'b0, 32'h000000F0);
        apply("r_or", 6'b000000, 6'b100101, 32'h0000F0F0, 32'h00000FF0, 32'd0, C_OR, 32'h0000FFF0, 1'b0, 1'b0, 32'h0000FFF0);
        apply("r_bad_func", 6'b000000, 6'b000000, 32'd5, 32'd7, 32'd0, C_NOP, 32'd12, 1'b0, 1'b0, 32'd12);
        apply("beq_taken", 6'b000100, 6'd0, 32'h1234, 32'h1234, 32'd0, C_BEQ, 32'd0, 1'b1, 1'b1, 32'd0);
        apply("beq_not_taken", 6'b000100, 6'd0, 32'd1, 32'd2, 32'd0, C_BEQ, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF);

        apply("sw_20", 6'b101011, 6'd0, 32'd16, 32'hDEADBEEF, 32'd4, C_SW, 32'd20, 1'b0, 1'b0, 32'd20);
        apply("lw_20", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'hDEADBEEF);
        apply("lw_20_alias", 6'b100011, 6'd0, 32'd20 + 32'(4 * MEM_DEPTH), 32'd0, 32'd0, C_LW,
              32'd20 + 32'(4 * MEM_DEPTH), 1'b0, 1'b0, 32'hDEADBEEF);
        apply("lw_23_byteoff", 6'b100011, 6'd0, 32'd20, 32'd0, 32'd3, C_LW, 32'd23, 1'b0, 1'b0, 32'hDEADBEEF);

        // Undecoded opcodes: B = read_data2 = 4 puts the address on word 20; a stray store would clobber it
        apply("undecoded_3f", 6'b111111, 6'd0, 32'd16, 32'd4, 32'd4, C_NOP, 32'd20, 1'b0, 1'b0, 32'd20);
`ifdef MIPS_EXEC_ADDI_EN
        apply("addi", 6'b001000, 6'd0, 32'd16, 32'd4, 32'd4, C_ADDI, 32'd20, 1'b0, 1'b0, 32'd20);
`else
        apply("addi_as_nop", 6'b001000, 6'd0, 32'd16, 32'd4, 32'd4, C_NOP, 32'd20, 1'b0, 1'b0, 32'd20);
`endif
        apply("lw_20_unchanged", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'hDEADBEEF);

        // Reset pulse mid-cycle; store attempted while reset is held
        @(posedge clk);
        #2 rst = 1'b0;
        apply("sw_in_reset", 6'b101011, 6'd0, 32'd16, 32'hCAFEF00D, 32'd4, C_SW, 32'd20, 1'b0, 1'b0, 32'd20);
        apply("lw_in_reset", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'd0);
        apply("add_in_reset", 6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0, C_ADD, 32'd12, 1'b0, 1'b0, 32'd12);
        @(posedge clk);
        #2 rst = 1'b1;
        apply("lw_20_cleared", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'd0);

        apply("sw_20_post", 6'b101011, 6'd0, 32'd16, 32'h55AA33CC, 32'd4, C_SW, 32'd20, 1'b0, 1'b0, 32'd20);
        apply("lw_20_post", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'h55AA33CC);
        apply("sw_top_word", 6'b101011, 6'd0, 32'(4 * (MEM_DEPTH - 1)), 32'h0BADF00D, 32'd0, C_SW,
              32'(4 * (MEM_DEPTH - 1)), 1'b0, 1'b0, 32'(4 * (MEM_DEPTH - 1)));
        apply("lw_top_alias", 6'b100011, 6'd0, 32'hFFFFFFF0, 32'd0, 32'd12, C_LW, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0BADF00D);
        apply("lw_20_intact", 6'b100011, 6'd0, 32'd16, 32'd0, 32'd4, C_LW, 32'd20, 1'b0, 1'b0, 32'h55AA33CC);

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d vectors left unchecked, expected 0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_exec_mem.md
MIPS_EXEC_MEM -- requirements
Module: mips_exec_mem

Interface
REQ-001 Parameter: MEM_DEPTH, default 256; number of 32-bit data-memory words, power of two.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, with ports named as follows.
- clk  in  1  clock; rising edge active.
- rst  in  1  asynchronous reset, active-low.
REQ-003 The block SHALL have these data and control ports.
- opcode  in  6  instruction bits [31:26].
- func  in  6  instruction bits [5:0].
- read_data1  in  32  register-file port 1; ALU operand A.
- read_data2  in  32  register-file port 2; ALU operand B candidate and store data.
- imm32  in  32  sign-extended immediate; ALU operand B candidate.
- RegDst, RegWrite, MemToReg, ALUSrc, MemRead, MemWrite, branch  out  1 each  decoded control signals.
- ALUOperation  out  2  ALU operation select.
- alu_result  out  32  ALU result.
- zero  out  1  high when alu_result equals 0.
- branch_taken  out  1  equals branch AND zero.
- write_data_reg  out  32  register write-back data.

Function
REQ-004 The decoder SHALL be purely combinational and decode opcode/func as follows.
- R-type (opcode 000000): RegDst=1, RegWrite=1; ALUOperation from func.
  - func 100000 (add) -> 00.
  - func 100010 (sub) -> 01.
  - func 100100 (and) -> 10.
  - func 100101 (or) -> 11.
  - Any other func -> all controls 0.
- lw (100011): ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUOperation=00.
- sw (101011): ALUSrc=1, MemWrite=1, ALUOperation=00.
- beq (000100): branch=1, ALUOperation=01.
REQ-005 Any opcode not decoded SHALL drive every control output to 0, making the instruction a NOP.
REQ-006 ALU operand B SHALL be imm32 when ALUSrc=1, else read_data2.
REQ-007 The ALU SHALL be combinational: 00 = A+B, 01 = A-B, 10 = A&B, 11 = A|B; results wrap modulo 2^32; no overflow flag.
REQ-008 The zero output SHALL equal (alu_result == 32'h0) in the same cycle.
REQ-009 Data memory SHALL be word-addressed by alu_result[log2(MEM_DEPTH)+1:2]; the low 2 bits and the upper bits SHALL be ignored, so addresses wrap.
REQ-010 Write SHALL occur on the clk rising edge when MemWrite=1 and rst=1, storing read_data2.
REQ-011 Memory read data SHALL be combinational: the addressed word when MemRead=1, else 32'h0.
REQ-012 A read of the address being written in the same cycle SHALL return the old word before the edge and the new word after it.
REQ-013 write_data_reg SHALL be the memory read data when MemToReg=1, else alu_result.

Reset
REQ-014 While rst=0, every memory word SHALL be cleared to 0 asynchronously, and writes SHALL be blocked.
REQ-015 Control and ALU outputs SHALL remain combinational functions of their inputs during reset; memory read data SHALL be 0 during reset.
REQ-016 A write coinciding with reset deassertion SHALL be ignored; the first write SHALL be accepted on the first rising edge with rst=1.

Configuration
REQ-017 Macro MIPS_EXEC_ADDI_EN SHALL control addi decoding.
- Defined: opcode 001000 (addi) decodes to ALUSrc=1, RegWrite=1, ALUOperation=00.
- Undefined: opcode 001000 is an undecoded NOP per REQ-005.

Structure
REQ-018 A shared package SHALL hold the opcode constants, the func constants, the 2-bit ALU operation encoding, and the MEM_DEPTH default.
REQ-019 The ALU SHALL be one sub-module, exec_alu; the decoder and memory SHALL be inline in mips_exec_mem.

Verification
REQ-020 The bench SHALL cover these directed scenarios.
- R add: opcode 0, func 100000, A=5, B=7 -> alu_result=12, zero=0, RegWrite=1, RegDst=1, write_data_reg=12.
- beq: opcode 000100, A=B=32'h1234 -> ALUOperation=01, alu_result=0, zero=1, branch_taken=1; with A=1, B=2 -> alu_result=32'hFFFFFFFF, branch_taken=0.
- sw then lw: sw with A=16, imm32=4, read_data2=32'hDEADBEEF, one clk edge; then lw with the same address -> write_data_reg=32'hDEADBEEF. Address 20+4*MEM_DEPTH reads the same word.
- Reset: after the store above, pulse rst=0 -> lw to address 20 returns 0. MemWrite asserted during reset leaves memory unchanged.
- Undecoded opcode 111111 (and opcode 001000 without MIPS_EXEC_ADDI_EN) -> all controls 0, no memory write.
- and/or: A=32'hF0F0, B=32'h0FF0 -> and gives 32'h00F0; or gives 32'hFFF0.
